// File: rtl/cc_miss_fill_ctrl.sv
// Cache hit-return / miss-fill controller: serves hits straight from the data-SRAM line,
// fetches missing lines with an 8-beat burst, writes tag+data SRAMs, then returns the word.
module cc_miss_fill_ctrl #(
  parameter int BEATS  = 8,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hit_i,
  input  logic                 miss_i,
  input  logic [16:0]          tag_i,
  input  logic [8:0]           index_i,
  input  logic [5:0]           offset_i,
  input  logic [511:0]         rdata_data_i,
  output logic                 busy_o,
  output logic [63:0]          inct_rdata_o,
  output logic                 inct_rvalid_o,
  input  logic                 inct_rready_i,
  output logic [ADDR_W-1:0]    mem_araddr_o,
  output logic                 mem_arvalid_o,
  input  logic                 mem_arready_i,
  input  logic [63:0]          mem_rdata_i,
  input  logic                 mem_rvalid_i,
  input  logic                 mem_rlast_i,
  output logic                 mem_rready_o,
  output logic                 wren_tag_o,
  output logic [17:0]          wdata_tag_o,
  output logic                 wren_data_o,
  output logic [511:0]         wdata_data_o,
  output logic [8:0]           windex_o
);

  localparam int TAG_W  = 17;
  localparam int IDX_W  = 9;
  localparam int OFF_W  = 6;
  localparam int WORD_W = 64;
  localparam int CNT_W  = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE,
    MEM_REQ,
    MEM_DATA,
    FILL,
    SERVE
  } state_t;

  state_t state_reg, state_next;

  logic [TAG_W-1:0]              tag_reg;
  logic [IDX_W-1:0]              index_reg;
  logic [CNT_W-1:0]              sel_reg;
  logic [CNT_W-1:0]              beat_cnt_reg;
  logic [BEATS-1:0][WORD_W-1:0]  line_reg;
  logic [WORD_W-1:0]             rdata_reg;
  logic [WORD_W-1:0]             hit_word [BEATS];
  logic [CNT_W-1:0]              offset_sel;

  logic latch_miss;
  logic latch_hit;
  logic cnt_clear;
  logic beat_accept;
  logic is_fill;

  // rlast is deliberately ignored (the burst length is fixed) and offset[2:0] never selects anything.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, mem_rlast_i, offset_i[OFF_W-CNT_W-1:0]};

  assign offset_sel = offset_i[OFF_W-1:OFF_W-CNT_W];

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_hit_word
      assign hit_word[gi] = rdata_data_i[gi*WORD_W +: WORD_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    latch_miss    = 1'b0;
    latch_hit     = 1'b0;
    cnt_clear     = 1'b0;
    beat_accept   = 1'b0;
    is_fill       = 1'b0;
    mem_arvalid_o = 1'b0;
    mem_rready_o  = 1'b0;
    inct_rvalid_o = 1'b0;
    case (state_reg)
      IDLE: begin
        // A miss takes priority when the tag stage flags both.
        if (miss_i) begin
          latch_miss = 1'b1;
          state_next = MEM_REQ;
        end else if (hit_i) begin
          latch_hit  = 1'b1;
          state_next = SERVE;
        end
      end
      MEM_REQ: begin
        mem_arvalid_o = 1'b1;
        if (mem_arready_i) begin
          cnt_clear  = 1'b1;
          state_next = MEM_DATA;
        end
      end
      MEM_DATA: begin
        mem_rready_o = 1'b1;
        if (mem_rvalid_i) begin
          beat_accept = 1'b1;
          if (beat_cnt_reg == CNT_W'(BEATS - 1)) begin
            state_next = FILL;
          end
        end
      end
      FILL: begin
        is_fill    = 1'b1;
        state_next = SERVE;
      end
      SERVE: begin
        inct_rvalid_o = 1'b1;
        if (inct_rready_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_reg      <= '0;
      index_reg    <= '0;
      sel_reg      <= '0;
      beat_cnt_reg <= '0;
      line_reg     <= '0;
      rdata_reg    <= '0;
    end else begin
      if (latch_miss) begin
        tag_reg   <= tag_i;
        index_reg <= index_i;
        sel_reg   <= offset_sel;
      end
      if (cnt_clear) begin
        beat_cnt_reg <= '0;
      end else if (beat_accept) begin
        beat_cnt_reg <= beat_cnt_reg + 1'b1;
      end
      if (beat_accept) begin
        line_reg[beat_cnt_reg] <= mem_rdata_i;
      end
      if (latch_hit) begin
        rdata_reg <= hit_word[offset_sel];
      end else if (is_fill) begin
        rdata_reg <= line_reg[sel_reg];
      end
    end
  end

  assign busy_o       = (state_reg != IDLE);
  assign inct_rdata_o = rdata_reg;
  assign mem_araddr_o = {tag_reg, index_reg, {OFF_W{1'b0}}};

  // SRAM write bus is only meaningful during the single FILL cycle; zero elsewhere.
  assign wren_tag_o   = is_fill;
  assign wren_data_o  = is_fill;
  assign wdata_tag_o  = is_fill ? {1'b1, tag_reg} : '0;
  assign wdata_data_o = is_fill ? line_reg : '0;
  assign windex_o     = is_fill ? index_reg : '0;

endmodule

// File: tb/tb_cc_miss_fill_ctrl.sv
// Self-checking bench for cc_miss_fill_ctrl: table-driven hits, directed miss/reset
// sequences, and randomized hit/miss traffic against a transaction-level model.
module tb_cc_miss_fill_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         hit_i, miss_i;
  logic [16:0]  tag_i;
  logic [8:0]   index_i;
  logic [5:0]   offset_i;
  logic [511:0] rdata_data_i;
  logic         busy_o;
  logic [63:0]  inct_rdata_o;
  logic         inct_rvalid_o, inct_rready_i;
  logic [31:0]  mem_araddr_o;
  logic         mem_arvalid_o, mem_arready_i;
  logic [63:0]  mem_rdata_i;
  logic         mem_rvalid_i, mem_rlast_i, mem_rready_o;
  logic         wren_tag_o, wren_data_o;
  logic [17:0]  wdata_tag_o;
  logic [511:0] wdata_data_o;
  logic [8:0]   windex_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cc_miss_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .hit_i(hit_i), .miss_i(miss_i),
    .tag_i(tag_i), .index_i(index_i), .offset_i(offset_i),
    .rdata_data_i(rdata_data_i), .busy_o(busy_o),
    .inct_rdata_o(inct_rdata_o), .inct_rvalid_o(inct_rvalid_o),
    .inct_rready_i(inct_rready_i), .mem_araddr_o(mem_araddr_o),
    .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rlast_i(mem_rlast_i), .mem_rready_o(mem_rready_o),
    .wren_tag_o(wren_tag_o), .wdata_tag_o(wdata_tag_o),
    .wren_data_o(wren_data_o), .wdata_data_o(wdata_data_o),
    .windex_o(windex_o)
  );

  typedef struct {
    logic [5:0]  offset;
    int          delay;
    logic [63:0] exp_word;
  } hit_vec_t;

  hit_vec_t hv [6];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] word_of(input logic [511:0] line, input int sel);
    logic [511:0] t;
    t = line >> (64 * sel);
    return t[63:0];
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic check_all_zero(input string name);
    chk({name, ".busy"},   busy_o, 0);
    chk({name, ".rvalid"}, inct_rvalid_o, 0);
    chk({name, ".rdata"},  inct_rdata_o, 0);
    chk({name, ".araddr"}, mem_araddr_o, 0);
    chk({name, ".arvalid"}, mem_arvalid_o, 0);
    chk({name, ".rready"}, mem_rready_o, 0);
    chk({name, ".wren_tag"}, wren_tag_o, 0);
    chk({name, ".wren_data"}, wren_data_o, 0);
    chk({name, ".wdata_tag"}, wdata_tag_o, 0);
    chk({name, ".wdata_data"}, wdata_data_o, 0);
    chk({name, ".windex"}, windex_o, 0);
  endtask

  // Called in the first SERVE cycle; holds off rready for 'delay' cycles, then handshakes.
  task automatic serve(input string name, input logic [63:0] exp_word, input int delay);
    chk({name, ".rvalid"}, inct_rvalid_o, 1);
    chk({name, ".rdata"},  inct_rdata_o, exp_word);
    chk({name, ".busy"},   busy_o, 1);
    chk({name, ".wren"},   wren_data_o, 0);
    inct_rready_i = 1'b0;
    for (int i = 0; i < delay; i++) begin
      step();
      chk({name, ".hold_rvalid"}, inct_rvalid_o, 1);
      chk({name, ".hold_rdata"},  inct_rdata_o, exp_word);
    end
    inct_rready_i = 1'b1;
    step();
    inct_rready_i = 1'b0;
    chk({name, ".done_rvalid"}, inct_rvalid_o, 0);
    chk({name, ".done_busy"},   busy_o, 0);
  endtask

  task automatic do_hit(input string name, input logic [5:0] off, input logic [511:0] line,
                        input logic [63:0] exp_word, input int delay);
    chk({name, ".idle_busy"}, busy_o, 0);
    hit_i        = 1'b1;
    offset_i     = off;
    tag_i        = 17'($urandom());
    index_i      = 9'($urandom());
    rdata_data_i = line;
    step();
    hit_i        = 1'b0;
    offset_i     = 6'($urandom());
    rdata_data_i = rand_line();
    serve(name, exp_word, delay);
    $display("hit  %s off=%02h word=%016h hold=%0d", name, off, exp_word, delay);
  endtask

  // gap_mode: 0 = rvalid every cycle, 1 = alternate 1/0, 2 = random.
  task automatic do_miss(input string name, input logic [16:0] tag, input logic [8:0] idx,
                         input logic [5:0] off, input int ar_delay, input logic [63:0] beats [8],
                         input int gap_mode, input int rlast_at, input bit with_hit,
                         input bit poke, input int delay);
    logic [31:0]  exp_addr;
    logic [17:0]  exp_tag;
    logic [511:0] exp_line;
    logic [63:0]  exp_word;
    int k, cyc;
    bit tog, v;
    exp_addr = (32'(tag) << 15) | (32'(idx) << 6);
    exp_tag  = 18'h20000 | 18'(tag);
    exp_line = '0;
    for (int i = 0; i < 8; i++) exp_line = exp_line | (512'(beats[i]) << (64 * i));
    exp_word = beats[off / 8];

    miss_i = 1'b1; hit_i = with_hit;
    tag_i = tag; index_i = idx; offset_i = off; rdata_data_i = rand_line();
    step();
    miss_i = 1'b0; hit_i = 1'b0;
    tag_i = 17'($urandom()); index_i = 9'($urandom()); offset_i = 6'($urandom());
    chk({name, ".arvalid"}, mem_arvalid_o, 1);
    chk({name, ".araddr"},  mem_araddr_o, exp_addr);
    chk({name, ".busy"},    busy_o, 1);
    chk({name, ".no_rvalid"}, inct_rvalid_o, 0);
    for (int i = 0; i < ar_delay; i++) begin
      step();
      chk({name, ".ar_hold"}, mem_arvalid_o, 1);
      chk({name, ".ar_addr_hold"}, mem_araddr_o, exp_addr);
    end
    mem_arready_i = 1'b1;
    step();
    mem_arready_i = 1'b0;
    chk({name, ".ar_drop"}, mem_arvalid_o, 0);
    chk({name, ".rready"},  mem_rready_o, 1);

    k = 0; cyc = 0; tog = 1'b1;
    while (k < 8 && cyc < 200) begin
      v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      mem_rvalid_i = v;
      mem_rdata_i  = v ? beats[k] : {$urandom(), $urandom()};
      mem_rlast_i  = v && (k == rlast_at);
      if (poke && cyc == 2) hit_i = 1'b1;
      if (poke && cyc == 4) miss_i = 1'b1;
      step();
      hit_i = 1'b0; miss_i = 1'b0;
      if (v) k++;
      cyc++;
      if (k < 8) begin
        chk({name, ".no_early_fill"}, wren_data_o, 0);
        chk({name, ".no_extra_ar"}, mem_arvalid_o, 0);
        chk({name, ".burst_rready"}, mem_rready_o, 1);
      end
    end
    if (k < 8) begin
      checks++; errors++;
      $display("FAIL %s.burst_timeout: got %0d beats expected 8", name, k);
    end
    mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
    chk({name, ".fill_wren_tag"},  wren_tag_o, 1);
    chk({name, ".fill_wren_data"}, wren_data_o, 1);
    chk({name, ".fill_windex"},    windex_o, idx);
    chk({name, ".fill_wdata_tag"}, wdata_tag_o, exp_tag);
    chk({name, ".fill_line"},      wdata_data_o, exp_line);
    chk({name, ".fill_rvalid"},    inct_rvalid_o, 0);
    step();
    chk({name, ".post_fill_wren"}, wren_tag_o, 0);
    serve(name, exp_word, delay);
    $display("miss %s tag=%05h idx=%03h off=%02h word=%016h", name, tag, idx, off, exp_word);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] hit_line;
    logic [63:0]  bt [8];
    logic [63:0]  tmp;

    hv[0] = '{offset: 6'h18, delay: 0, exp_word: 64'hDEAD_BEEF_0000_0003};
    hv[1] = '{offset: 6'h18, delay: 5, exp_word: 64'hDEAD_BEEF_0000_0003};
    hv[2] = '{offset: 6'h00, delay: 1, exp_word: 64'hDEAD_BEEF_0000_0000};
    hv[3] = '{offset: 6'h3F, delay: 2, exp_word: 64'hDEAD_BEEF_0000_0007};
    hv[4] = '{offset: 6'h27, delay: 0, exp_word: 64'hDEAD_BEEF_0000_0004};
    hv[5] = '{offset: 6'h0B, delay: 3, exp_word: 64'hDEAD_BEEF_0000_0001};
    for (int i = 0; i < 8; i++) hit_line[64*i +: 64] = 64'hDEAD_BEEF_0000_0000 | 64'(i);

    rst_n = 1'b0; hit_i = 1'b0; miss_i = 1'b0; tag_i = '0; index_i = '0; offset_i = '0;
    rdata_data_i = '0; inct_rready_i = 1'b0; mem_arready_i = 1'b0;
    mem_rdata_i = '0; mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
    step(); step(); step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) do_hit($sformatf("hitvec%0d", i), hv[i].offset, hit_line, hv[i].exp_word, hv[i].delay);

    for (int i = 0; i < 8; i++) bt[i] = 64'(i);
    do_miss("miss_plan", 17'h1ABCD, 9'h055, 6'h28, 3, bt, 0, -1, 1'b0, 1'b0, 0);
    do_miss("beat_gaps", 17'h0_1234, 9'h1FF, 6'h3A, 0, bt, 1, 4, 1'b0, 1'b0, 1);
    for (int i = 0; i < 8; i++) bt[i] = {$urandom(), $urandom()};
    do_miss("ignored_pulses", 17'h1FFFF, 9'h000, 6'h10, 1, bt, 1, -1, 1'b0, 1'b1, 2);
    do_miss("hit_and_miss", 17'h00001, 9'h100, 6'h08, 0, bt, 0, -1, 1'b1, 1'b0, 0);

    // Reset mid-burst: four beats in, then reset while the fifth beat is offered.
    miss_i = 1'b1; tag_i = 17'h00F0F; index_i = 9'h1A0; offset_i = 6'h00;
    step();
    miss_i = 1'b0; mem_arready_i = 1'b1;
    step();
    mem_arready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 64'(100 + k);
      step();
    end
    mem_rdata_i = 64'd104; rst_n = 1'b0;
    step();
    check_all_zero("rst_mid");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_mid.rready_off", mem_rready_o, 0);
      chk("rst_mid.no_wren", wren_data_o, 0);
      chk("rst_mid.idle", busy_o, 0);
    end
    mem_rvalid_i = 1'b0;
    $display("rst  mid-burst reset applied after 4 beats");
    for (int i = 0; i < 8; i++) bt[i] = 64'hA5A5_0000_0000_0000 | 64'(i * 3);
    do_miss("after_reset", 17'h0AAAA, 9'h0F0, 6'h38, 2, bt, 0, -1, 1'b0, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      int kind;
      logic [5:0] off;
      kind = $urandom_range(0, 2);
      off  = 6'($urandom());
      if (kind == 0) begin
        hit_line = rand_line();
        tmp = word_of(hit_line, off / 8);
        do_hit($sformatf("rnd%0d", t), off, hit_line, tmp, $urandom_range(0, 3));
      end else begin
        for (int i = 0; i < 8; i++) bt[i] = {$urandom(), $urandom()};
        do_miss($sformatf("rnd%0d", t), 17'($urandom()), 9'($urandom()), off,
                $urandom_range(0, 3), bt, 2, $urandom_range(0, 7), kind == 2,
                1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cc_miss_fill_ctrl.md
Name: cc_miss_fill_ctrl

Overview:
- Sits directly downstream of the cache tag-compare stage and consumes its delayed tag/index/offset and hit/miss outputs.
- On a hit, returns the requested 64-bit word from the data-SRAM line to the core.
- On a miss, fetches the 64-byte line from memory with an 8-beat burst, writes the tag and data SRAMs, then returns the word.
- Holds busy_o while active so upstream issues no new lookup.

Parameters:
- BEATS, 8, memory beats per line (64-byte line / 64-bit beat); fixed by the 6-bit offset.
- ADDR_W, 32, memory address width, equal to tag(17)+index(9)+offset(6).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- hit_i  in  1  single-cycle hit pulse from tag compare
- miss_i  in  1  single-cycle miss pulse from tag compare
- tag_i  in  17  delayed tag, valid with hit_i/miss_i
- index_i  in  9  delayed index
- offset_i  in  6  delayed byte offset
- rdata_data_i  in  512  data-SRAM line, valid in the hit_i cycle
- busy_o  out  1  controller not IDLE; upstream must not pulse
- inct_rdata_o  out  64  word returned to core
- inct_rvalid_o  out  1  return word valid
- inct_rready_i  in  1  core accepts word
- mem_araddr_o  out  32  line-aligned read address
- mem_arvalid_o  out  1  read request valid
- mem_arready_i  in  1  read request accepted
- mem_rdata_i  in  64  read beat data
- mem_rvalid_i  in  1  read beat valid
- mem_rlast_i  in  1  last beat (not used for control)
- mem_rready_o  out  1  beat accept
- wren_tag_o  out  1  tag-SRAM write enable
- wdata_tag_o  out  18  {valid=1, tag}
- wren_data_o  out  1  data-SRAM write enable
- wdata_data_o  out  512  filled line
- windex_o  out  9  write index for both SRAMs

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. All valid, enable and busy outputs go to 0. All data/address outputs go to 0. The beat counter and line buffer clear.
- Reset mid-burst abandons the transfer. mem_rready_o=0 from the next cycle, so later beats are not accepted. No SRAM write occurs.
- Word select is offset[5:3]; offset[2:0] is ignored. Word k = line bits [64k+63:64k].
- States: IDLE, MEM_REQ, MEM_DATA, FILL, SERVE.
- IDLE:
  - hit_i: latch the selected word of rdata_data_i into inct_rdata_o and go to SERVE. inct_rvalid_o=1 in cycle N+1 of hit cycle N.
  - miss_i: latch tag, index and word select, then go to MEM_REQ. If hit_i and miss_i are both 1, miss wins.
- MEM_REQ:
  - mem_arvalid_o=1 with mem_araddr_o={tag,index,6'b0}, held stable until mem_arready_i.
  - On handshake go to MEM_DATA and clear the beat counter.
  - arvalid rises in cycle N+1 after the miss cycle N.
- MEM_DATA:
  - mem_rready_o=1. Each cycle with mem_rvalid_i stores mem_rdata_i into buffer slot beat_cnt, then increments the 3-bit counter.
  - The 8th accepted beat (cnt=7) ends the burst and moves to FILL. mem_rlast_i is ignored, and gaps in rvalid are tolerated.
- FILL (exactly 1 cycle):
  - wren_tag_o=wren_data_o=1 and windex_o=latched index.
  - wdata_tag_o={1'b1,tag} and wdata_data_o=the full buffer, with the beat-7 data included.
  - inct_rdata_o loads buffer word[sel]; go to SERVE.
- SERVE:
  - inct_rvalid_o=1 and inct_rdata_o is held stable until inct_rready_i, then go to IDLE.
  - Miss latency: last beat at cycle M gives FILL at M+1 and rvalid at M+2.
- busy_o = (state != IDLE). It is registered from state, so it rises the cycle after hit_i/miss_i.
- hit_i/miss_i outside IDLE are ignored. Upstream must not pulse while busy_o=1.
- Back-to-back: IDLE is entered the cycle after the rready handshake, and a hit_i in that cycle is accepted.
- SRAM enables are single-cycle pulses, asserted only in FILL.

Test Plan:
- Hit: hit_i with offset=6'h18 and rdata_data_i word3=64'hDEAD_BEEF_0000_0003 -> next cycle inct_rvalid_o=1, inct_rdata_o=that word, busy_o=1; rready=1 -> IDLE, busy_o=0.
- Hit with backpressure: rready held 0 for 5 cycles -> rvalid and rdata stay stable all 5 cycles; released after the handshake.
- Miss fill: miss_i tag=17'h1ABCD index=9'h055 offset=6'h28 -> araddr=32'hD5E6_9540, arvalid held until arready (3-cycle delay); beats 64'h0..64'h7 -> FILL pulse with windex=0x055, wdata_tag=18'h3ABCD, line word k=k; then inct_rdata_o=64'h5.
- Beat gaps: rvalid toggled 1,0,1,0,...; rlast asserted early on beat 4 -> FILL only after the 8th accepted beat, line correct.
- Reset mid-burst: rst_n=0 after beat 3 -> next cycle all outputs 0 and IDLE; no wren pulses; a new miss then completes normally.
- Ignored pulses: hit_i/miss_i pulsed during MEM_DATA -> no state change and no extra arvalid.
